// File: rtl/thermal_frame_reader_pkg.sv
// Shared definitions for the thermal frame reader: FSM states, I2C R/W constants and the
// command word layout driven towards the byte-level I2C controller.
package thermal_frame_reader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RECOVER,
        ST_DEV_W,
        ST_REG_HI,
        ST_REG_LO,
        ST_DEV_R,
        ST_RD_HI,
        ST_RD_LO,
        ST_DONE,
        ST_ABORT
    } state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    // Field order is the controller's command bus, MSB first.
    typedef struct packed {
        logic       start;
        logic       stop;
        logic       write;
        logic       read;
        logic       ack;
        logic [7:0] data;
    } i2c_cmd_t;

    localparam i2c_cmd_t CMD_IDLE = '0;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

    function automatic i2c_cmd_t cmd_wr(input logic with_start, input logic [7:0] data);
        i2c_cmd_t c;
        c       = CMD_IDLE;
        c.start = with_start;
        c.write = 1'b1;
        c.data  = data;
        return c;
    endfunction

    function automatic i2c_cmd_t cmd_rd(input logic ack, input logic with_stop);
        i2c_cmd_t c;
        c      = CMD_IDLE;
        c.read = 1'b1;
        c.ack  = ack;
        c.stop = with_stop;
        return c;
    endfunction

    function automatic i2c_cmd_t cmd_stop_only();
        i2c_cmd_t c;
        c      = CMD_IDLE;
        c.stop = 1'b1;
        return c;
    endfunction

    function automatic logic issues_cmd(input state_t s);
        return !(s inside {ST_IDLE, ST_DONE});
    endfunction

    // States whose byte is a write, so a slave NACK there aborts the frame.
    function automatic logic is_write_state(input state_t s);
        return s inside {ST_DEV_W, ST_REG_HI, ST_REG_LO, ST_DEV_R};
    endfunction

endpackage

// File: rtl/thermal_frame_reader_watchdog.sv
// Loadable down-counter that flags a command left unanswered for TIMEOUT_CYCLES cycles.
module thermal_frame_reader_watchdog #(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT_CYCLES);
        end else if (clear) begin
            count <= '0;
        end else if (run && count != '0) begin
            count <= count - CW'(1);
        end
    end

    // Fires in the last allowed waiting cycle; the count then sits at zero until reloaded.
    assign expire = run && (count == CW'(1));

endmodule

// File: rtl/thermal_frame_reader.sv
// Frame read sequencer: one addressed I2C read of WORD_COUNT big-endian 16-bit registers,
// streamed out as indexed words.
module thermal_frame_reader
    import thermal_frame_reader_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = 7'h33,
    parameter logic [15:0] BASE_REG       = 16'h0400,
    parameter int          WORD_COUNT     = 768,
    parameter int          TIMEOUT_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_start,
    output logic        cmd_stop,
    output logic        cmd_write,
    output logic        cmd_read,
    output logic        cmd_ack,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic        word_valid,
    output logic [15:0] word_data,
    output logic [15:0] word_index,
    output logic        frame_done,
    output logic        error
);

    state_t   state;
    state_t   state_d;
    i2c_cmd_t cmd;

    logic        pending;
    logic        recover_flag;
    logic [15:0] word_cnt;
    logic [7:0]  hi_byte;

    logic handshake;
    logic rsp_done;
    logic start_ok;
    logic last_word;
    logic write_nack;
    logic timeout;
    logic wd_run;
    logic wd_clear;

    assign handshake  = cmd_valid && cmd_ready;
    assign rsp_done   = pending && rsp_valid;
    assign start_ok   = start && (state == ST_IDLE);
    assign last_word  = (word_cnt == 16'(WORD_COUNT - 1));
    assign write_nack = rsp_done && rsp_nack && is_write_state(state);

    // Only a response that is actually owed is timed; waiting on cmd_ready never times out.
    assign wd_run   = pending && !rsp_valid;
    assign wd_clear = !pending;

    thermal_frame_reader_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .load  (handshake),
        .clear (wd_clear),
        .run   (wd_run),
        .expire(timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d = state;
        cmd     = CMD_IDLE;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = recover_flag ? ST_RECOVER : ST_DEV_W;
                end
            end
            ST_RECOVER: begin
                cmd = cmd_stop_only();
                if (rsp_done) state_d = ST_DEV_W;
            end
            ST_DEV_W: begin
                cmd = cmd_wr(1'b1, addr_byte(DEV_ADDR, I2C_RW_WRITE));
                if (rsp_done) state_d = rsp_nack ? ST_ABORT : ST_REG_HI;
            end
            ST_REG_HI: begin
                cmd = cmd_wr(1'b0, BASE_REG[15:8]);
                if (rsp_done) state_d = rsp_nack ? ST_ABORT : ST_REG_LO;
            end
            ST_REG_LO: begin
                cmd = cmd_wr(1'b0, BASE_REG[7:0]);
                if (rsp_done) state_d = rsp_nack ? ST_ABORT : ST_DEV_R;
            end
            ST_DEV_R: begin
                cmd = cmd_wr(1'b1, addr_byte(DEV_ADDR, I2C_RW_READ));
                if (rsp_done) state_d = rsp_nack ? ST_ABORT : ST_RD_HI;
            end
            ST_RD_HI: begin
                cmd = cmd_rd(1'b1, 1'b0);
                if (rsp_done) state_d = ST_RD_LO;
            end
            ST_RD_LO: begin
                // The closing STOP rides on the final low byte, which is NACKed.
                cmd = cmd_rd(!last_word, last_word);
                if (rsp_done) state_d = last_word ? ST_DONE : ST_RD_HI;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                cmd = cmd_stop_only();
                if (rsp_done) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout) state_d = ST_IDLE;
    end

    assign cmd_valid  = issues_cmd(state) && !pending;
    assign {cmd_start, cmd_stop, cmd_write, cmd_read, cmd_ack, cmd_data} = cmd;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= 1'b0;
            recover_flag <= 1'b1;
            word_cnt     <= '0;
            hi_byte      <= '0;
            word_valid   <= 1'b0;
            word_data    <= '0;
            word_index   <= '0;
            error        <= 1'b0;
        end else begin
            word_valid <= 1'b0;

            if (timeout) begin
                pending <= 1'b0;
            end else if (handshake) begin
                pending <= 1'b1;
            end else if (rsp_valid) begin
                pending <= 1'b0;
            end

            // A bus abandoned by a timeout may still be mid-transfer, so free it next time.
            if (timeout) begin
                recover_flag <= 1'b1;
            end else if (rsp_done && state == ST_RECOVER) begin
                recover_flag <= 1'b0;
            end

            if (start_ok) begin
                word_cnt <= '0;
                error    <= 1'b0;
            end

            if (rsp_done && state == ST_RD_HI) begin
                hi_byte <= rsp_data;
            end

            if (rsp_done && state == ST_RD_LO) begin
                word_valid <= 1'b1;
                word_data  <= {hi_byte, rsp_data};
                word_index <= word_cnt;
                word_cnt   <= word_cnt + 16'd1;
            end

            if (write_nack || timeout) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_thermal_frame_reader.sv
// Directed bench for thermal_frame_reader: a cycle-stepped slave model with command and
// word scoreboards, covering clean frames, recovery, NACK abort, timeout and reset.
module tb_thermal_frame_reader;
    import thermal_frame_reader_pkg::*;

    localparam int WORDS     = 4;
    localparam int TMO       = 8;
    localparam int RSP_DELAY = 2;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        start     = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [7:0]  rsp_data  = '0;
    logic        rsp_nack  = 1'b0;
    logic        busy;
    logic        cmd_valid;
    logic        cmd_start;
    logic        cmd_stop;
    logic        cmd_write;
    logic        cmd_read;
    logic        cmd_ack;
    logic [7:0]  cmd_data;
    logic        word_valid;
    logic [15:0] word_data;
    logic [15:0] word_index;
    logic        frame_done;
    logic        error;

    thermal_frame_reader #(
        .DEV_ADDR      (7'h33),
        .BASE_REG      (16'h0400),
        .WORD_COUNT    (WORDS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .cmd_write (cmd_write),
        .cmd_read  (cmd_read),
        .cmd_ack   (cmd_ack),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_nack  (rsp_nack),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_index(word_index),
        .frame_done(frame_done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] index;
    } word_t;

    i2c_cmd_t cmd_q[$];
    word_t    word_q[$];

    int n_asserts = 0;
    int n_fail    = 0;

    int       rsp_timer     = 0;
    int       ready_hold    = 0;
    int       reads_seen    = 0;
    int       words_seen    = 0;
    int       done_seen     = 0;
    bit       outstanding   = 1'b0;
    bit       stalled       = 1'b0;
    bit       nack_armed    = 1'b0;
    bit       drop_armed    = 1'b0;
    bit       dropped       = 1'b0;
    bit       start_req     = 1'b0;
    bit       start_on_done = 1'b0;
    logic     rsp_nack_next = 1'b0;
    logic [7:0] rd_byte   = 8'h01;
    logic [7:0] rsp_byte  = 8'h00;
    logic [7:0] nack_byte = 8'h00;
    logic [7:0] drop_byte = 8'h00;
    i2c_cmd_t stall_cmd   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic i2c_cmd_t mk(input logic s, input logic p, input logic w,
                                    input logic r, input logic a, input logic [7:0] d);
        i2c_cmd_t c;
        c.start = s;
        c.stop  = p;
        c.write = w;
        c.read  = r;
        c.ack   = a;
        c.data  = d;
        return c;
    endfunction

    task automatic accept(input i2c_cmd_t obs);
        i2c_cmd_t exp_cmd;
        if (cmd_q.size() == 0) begin
            check("cmd_unexpected", 32'(obs), 32'hffff_ffff);
        end else begin
            exp_cmd = cmd_q.pop_front();
            check("cmd_fields", 32'(obs), 32'(exp_cmd));
        end
        outstanding = 1'b1;
        if (obs.read) begin
            rsp_byte = rd_byte;
            rd_byte  = rd_byte + 8'd1;
            reads_seen++;
        end else begin
            rsp_byte = 8'h00;
        end
        rsp_nack_next = obs.write && nack_armed && (obs.data == nack_byte);
        if (rsp_nack_next) nack_armed = 1'b0;
        if (obs.write && drop_armed && obs.data == drop_byte) begin
            drop_armed = 1'b0;
            dropped    = 1'b1;
            rsp_timer  = 0;
        end else begin
            rsp_timer = RSP_DELAY;
        end
    endtask

    // One clock cycle: sample at the falling edge, then drive inputs for the next rising edge.
    task automatic step();
        i2c_cmd_t obs;
        word_t    w;
        bit       ready_now;
        @(negedge clk);
        start     = start_req || (start_on_done && frame_done);
        start_req = 1'b0;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        obs = {cmd_start, cmd_stop, cmd_write, cmd_read, cmd_ack, cmd_data};

        if (word_valid) begin
            words_seen++;
            if (word_q.size() == 0) begin
                check("word_unexpected", 32'(word_valid), 32'd0);
            end else begin
                w = word_q.pop_front();
                check("word_data", 32'(word_data), 32'(w.data));
                check("word_index", 32'(word_index), 32'(w.index));
            end
        end
        if (frame_done) done_seen++;

        if (rsp_timer > 0) begin
            rsp_timer--;
            if (rsp_timer == 0) begin
                rsp_valid   = 1'b1;
                rsp_data    = rsp_byte;
                rsp_nack    = rsp_nack_next;
                outstanding = 1'b0;
            end
        end

        ready_now = (ready_hold == 0);
        cmd_ready = ready_now;
        if (cmd_valid) begin
            if (outstanding) check("one_outstanding", 32'(cmd_valid), 32'd0);
            if (!ready_now) begin
                if (stalled) check("cmd_stable", 32'(obs), 32'(stall_cmd));
                stall_cmd = obs;
                stalled   = 1'b1;
                ready_hold--;
            end else begin
                stalled = 1'b0;
                accept(obs);
            end
        end else begin
            stalled = 1'b0;
        end
    endtask

    task automatic expect_frame(input bit recover);
        word_t w;
        if (recover) cmd_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
        cmd_q.push_back(mk(1, 0, 1, 0, 0, 8'h66));
        cmd_q.push_back(mk(0, 0, 1, 0, 0, 8'h04));
        cmd_q.push_back(mk(0, 0, 1, 0, 0, 8'h00));
        cmd_q.push_back(mk(1, 0, 1, 0, 0, 8'h67));
        for (int i = 0; i < WORDS; i++) begin
            cmd_q.push_back(mk(0, 0, 0, 1, 1, 8'h00));
            if (i == WORDS - 1) cmd_q.push_back(mk(0, 1, 0, 1, 0, 8'h00));
            else                cmd_q.push_back(mk(0, 0, 0, 1, 1, 8'h00));
            w.data  = {8'(2 * i + 1), 8'(2 * i + 2)};
            w.index = 16'(i);
            word_q.push_back(w);
        end
    endtask

    task automatic kick(input string tag);
        done_seen   = 0;
        words_seen  = 0;
        reads_seen  = 0;
        rd_byte     = 8'h01;
        outstanding = 1'b0;
        dropped     = 1'b0;
        start_req   = 1'b1;
        step();
        step();
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_error_after_start"}, 32'(error), 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check({tag, "_idle_within_budget"}, 32'(busy), 32'd0);
    endtask

    task automatic finish_frame(input string tag, input int exp_words, input int exp_done,
                                input logic exp_err);
        wait_idle(tag, 300);
        repeat (4) step();
        check({tag, "_busy_stays_low"}, 32'(busy), 32'd0);
        check({tag, "_word_count"}, 32'(words_seen), 32'(exp_words));
        check({tag, "_frame_done_cycles"}, 32'(done_seen), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_cmds_left"}, 32'(cmd_q.size()), 32'd0);
        check({tag, "_words_left"}, 32'(word_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 32'({busy, cmd_valid, cmd_start, cmd_stop, cmd_write, cmd_read,
                                   cmd_ack, cmd_data, word_valid, frame_done, error}), 32'd0);
        check({tag, "_word_data"}, 32'(word_data), 32'd0);
        check({tag, "_word_index"}, 32'(word_index), 32'd0);
    endtask

    initial begin
        int n;

        #1 reset = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (3) step();
        reset = 1'b0;
        step();
        check_outputs_zero("post_reset");

        // Clean frame after reset: recovery stop, pointer write, burst read.
        expect_frame(1'b1);
        kick("f1");
        finish_frame("f1", WORDS, 1, 1'b0);

        // Second frame skips recovery; start mid-frame and in the frame_done cycle is ignored.
        expect_frame(1'b0);
        kick("f2");
        repeat (20) step();
        start_req     = 1'b1;
        start_on_done = 1'b1;
        finish_frame("f2", WORDS, 1, 1'b0);
        start_on_done = 1'b0;

        // Device address NACK aborts with a single stop-only command.
        nack_armed = 1'b1;
        nack_byte  = 8'h66;
        cmd_q.push_back(mk(1, 0, 1, 0, 0, 8'h66));
        cmd_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
        kick("f3");
        finish_frame("f3", 0, 0, 1'b1);

        // Next start clears the sticky error and runs a normal frame.
        expect_frame(1'b0);
        kick("f4");
        finish_frame("f4", WORDS, 1, 1'b0);

        // Stall cmd_ready, then never answer the register-high write.
        ready_hold = 10;
        drop_armed = 1'b1;
        drop_byte  = 8'h04;
        cmd_q.push_back(mk(1, 0, 1, 0, 0, 8'h66));
        cmd_q.push_back(mk(0, 0, 1, 0, 0, 8'h04));
        kick("f5");
        n = 0;
        while (!dropped && n < 100) begin
            step();
            n++;
        end
        check("f5_drop_reached", 32'(dropped), 32'd1);
        repeat (TMO - 2) step();
        check("f5_busy_before_timeout", 32'(busy), 32'd1);
        check("f5_error_before_timeout", 32'(error), 32'd0);
        wait_idle("f5", 6);
        check("f5_error_after_timeout", 32'(error), 32'd1);
        check("f5_cmds_left", 32'(cmd_q.size()), 32'd0);
        repeat (3) step();

        // After a timeout the frame opens with recovery; reset lands during word 2's low byte.
        expect_frame(1'b1);
        kick("f6");
        n = 0;
        while (reads_seen < 6 && n < 300) begin
            step();
            n++;
        end
        check("f6_reached_word2_lo", 32'(reads_seen), 32'd6);
        step();
        check("f6_words_before_reset", 32'(words_seen), 32'd2);
        #1 reset = 1'b1;
        #1 check_outputs_zero("mid_reset");
        cmd_q.delete();
        word_q.delete();
        rsp_timer   = 0;
        outstanding = 1'b0;
        stalled     = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();

        expect_frame(1'b1);
        kick("f7");
        finish_frame("f7", WORDS, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
